// File: rtl/text_buffer.sv
// text_buffer: character-cell text memory placed directly upstream of the pixel encoder.
//
// Bytes arrive over a valid/ready handshake. The block handles printable codes,
// newline, backspace and form feed. It keeps a cursor and scrolls the screen by
// one row when output runs past the bottom line. A combinational read port returns
// the glyph code for the cell at (rd_row, rd_col).
//
// Ports:
//   clk           system clock; all state changes on the rising edge
//   reset         synchronous, active-high reset; restarts the screen clear
//   in_data       incoming character or control code
//   in_valid      in_data is valid
//   in_ready      a byte can be accepted this cycle (IDLE only)
//   rd_row        read row, driven by the pixel encoder char_row
//   rd_col        read column, driven by the pixel encoder char_col
//   character_id  combinational cell contents at rd_row/rd_col (blank if out of range)
//   cursor_row    current cursor row
//   cursor_col    current cursor column
//   busy          a clear or a scroll is in progress (always ~in_ready)
//
// state        | meaning
// -------------+-------------------------------------------------------------
// CLEAR        | write BLANK_CHAR to every cell, one cell per cycle (600 cycles)
// IDLE         | in_ready high; accept and interpret one byte per cycle
// SCROLL_COPY  | mem[idx] = mem[idx+COL_NUMBER] for the top 14 rows (560 cycles)
// SCROLL_BLANK | blank the bottom row (40 cycles), then return to IDLE

module text_buffer #(
    parameter int ROW_NUMBER     = 15,
    parameter int COL_NUMBER     = 40,
    parameter int ROW_BIT_LEN    = 4,
    parameter int COL_BIT_LEN    = 6,
    parameter int CHAR_ID_LENGTH = 8,
    parameter int ADDR_BIT_LEN   = 10,
    parameter logic [CHAR_ID_LENGTH-1:0] BLANK_CHAR = 8'h20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROW_BIT_LEN-1:0]    rd_row,
    input  logic [COL_BIT_LEN-1:0]    rd_col,
    output logic [CHAR_ID_LENGTH-1:0] character_id,
    output logic [ROW_BIT_LEN-1:0]    cursor_row,
    output logic [COL_BIT_LEN-1:0]    cursor_col,
    output logic                      busy
);

    localparam int CELLS = ROW_NUMBER * COL_NUMBER;

    localparam logic [ADDR_BIT_LEN-1:0] ROW_STRIDE = ADDR_BIT_LEN'(COL_NUMBER);
    localparam logic [ADDR_BIT_LEN-1:0] LAST_CELL  = ADDR_BIT_LEN'(CELLS - 1);
    localparam logic [ADDR_BIT_LEN-1:0] LAST_COPY  = ADDR_BIT_LEN'(CELLS - COL_NUMBER - 1);
    localparam logic [ROW_BIT_LEN-1:0]  LAST_ROW   = ROW_BIT_LEN'(ROW_NUMBER - 1);
    localparam logic [COL_BIT_LEN-1:0]  LAST_COL   = COL_BIT_LEN'(COL_NUMBER - 1);
    localparam logic [ROW_BIT_LEN-1:0]  ROW_LIMIT  = ROW_BIT_LEN'(ROW_NUMBER);
    localparam logic [COL_BIT_LEN-1:0]  COL_LIMIT  = COL_BIT_LEN'(COL_NUMBER);

    typedef enum logic [1:0] {
        CLEAR        = 2'd0,
        IDLE         = 2'd1,
        SCROLL_COPY  = 2'd2,
        SCROLL_BLANK = 2'd3
    } state_t;

    state_t                    state;
    logic [ADDR_BIT_LEN-1:0]   idx;
    logic [CHAR_ID_LENGTH-1:0] mem [0:CELLS-1];

    logic [ADDR_BIT_LEN-1:0]   cursor_addr;
    logic [ADDR_BIT_LEN-1:0]   rd_addr;
    logic [ADDR_BIT_LEN-1:0]   copy_src;
    logic                      rd_in_range;
    logic                      accept;
    logic                      printable;
    logic                      at_origin;

    logic                      wr_en;
    logic [ADDR_BIT_LEN-1:0]   wr_addr;
    logic [CHAR_ID_LENGTH-1:0] wr_data;

    assign cursor_addr = ADDR_BIT_LEN'(cursor_row) * ROW_STRIDE + ADDR_BIT_LEN'(cursor_col);
    assign rd_addr     = ADDR_BIT_LEN'(rd_row) * ROW_STRIDE + ADDR_BIT_LEN'(rd_col);
    // Only used in SCROLL_COPY, where idx <= LAST_COPY, so the sum stays inside the array.
    assign copy_src    = idx + ROW_STRIDE;
    assign rd_in_range = (rd_row < ROW_LIMIT) && (rd_col < COL_LIMIT);
    assign accept      = in_valid && in_ready;
    assign printable   = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign at_origin   = (cursor_row == '0) && (cursor_col == '0);

    assign character_id = rd_in_range ? mem[rd_addr] : BLANK_CHAR;
    assign busy         = ~in_ready;

    // Single RAM write port shared by the clear, the scroll and byte handling.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = idx;
        wr_data = BLANK_CHAR;
        if (!reset) begin
            case (state)
                CLEAR, SCROLL_BLANK: wr_en = 1'b1;
                SCROLL_COPY: begin
                    wr_en   = 1'b1;
                    wr_data = mem[copy_src];
                end
                IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            wr_en   = 1'b1;
                            wr_addr = cursor_addr;
                            wr_data = in_data;
                        end else if (in_data == 8'h08 && !at_origin) begin
                            // Both backspace cases land on the previous linear cell:
                            // (r,c-1) or (r-1,39) == r*40-1.
                            wr_en   = 1'b1;
                            wr_addr = cursor_addr - ADDR_BIT_LEN'(1);
                        end
                    end
                end
                default: wr_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            idx        <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            in_ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (idx == LAST_CELL) begin
                        state    <= IDLE;
                        idx      <= '0;
                        in_ready <= 1'b1;
                    end else begin
                        idx <= idx + ADDR_BIT_LEN'(1);
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            if (cursor_col == LAST_COL) begin
                                cursor_col <= '0;
                                if (cursor_row == LAST_ROW) begin
                                    state    <= SCROLL_COPY;
                                    idx      <= '0;
                                    in_ready <= 1'b0;
                                end else begin
                                    cursor_row <= cursor_row + ROW_BIT_LEN'(1);
                                end
                            end else begin
                                cursor_col <= cursor_col + COL_BIT_LEN'(1);
                            end
                        end else if (in_data == 8'h0D || in_data == 8'h0A) begin
                            cursor_col <= '0;
                            if (cursor_row == LAST_ROW) begin
                                state    <= SCROLL_COPY;
                                idx      <= '0;
                                in_ready <= 1'b0;
                            end else begin
                                cursor_row <= cursor_row + ROW_BIT_LEN'(1);
                            end
                        end else if (in_data == 8'h08) begin
                            if (cursor_col != '0) begin
                                cursor_col <= cursor_col - COL_BIT_LEN'(1);
                            end else if (cursor_row != '0) begin
                                cursor_row <= cursor_row - ROW_BIT_LEN'(1);
                                cursor_col <= LAST_COL;
                            end
                        end else if (in_data == 8'h0C) begin
                            cursor_row <= '0;
                            cursor_col <= '0;
                            state      <= CLEAR;
                            idx        <= '0;
                            in_ready   <= 1'b0;
                        end
                    end
                end
                SCROLL_COPY: begin
                    if (idx == LAST_COPY) begin
                        state <= SCROLL_BLANK;
                    end
                    idx <= idx + ADDR_BIT_LEN'(1);
                end
                SCROLL_BLANK: begin
                    if (idx == LAST_CELL) begin
                        state    <= IDLE;
                        idx      <= '0;
                        in_ready <= 1'b1;
                    end else begin
                        idx <= idx + ADDR_BIT_LEN'(1);
                    end
                end
                default: begin
                    state    <= CLEAR;
                    idx      <= '0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
